// File: rtl/control_hazard_pipeline_if.sv
// Decoder-to-pipeline control bundle for the instruction sitting in ID.
// The decoder drives it (master); the hazard/pipeline block consumes it (slave).
interface control_hazard_pipeline_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 2
);
  logic                      id_jump;
  logic                      id_mem_to_reg;
  logic                      id_mem_write;
  logic                      id_branch;
  logic                      id_alu_src;
  logic                      id_reg_dst;
  logic                      id_reg_write;
  logic [ALU_OP_WIDTH-1:0]   id_alu_op;
  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic [REG_ADDR_WIDTH-1:0] id_rd;

  modport master (
    output id_jump, id_mem_to_reg, id_mem_write, id_branch, id_alu_src,
           id_reg_dst, id_reg_write, id_alu_op, id_rs, id_rt, id_rd
  );
  modport slave (
    input  id_jump, id_mem_to_reg, id_mem_write, id_branch, id_alu_src,
           id_reg_dst, id_reg_write, id_alu_op, id_rs, id_rt, id_rd
  );
endinterface

// File: rtl/control_hazard_pipeline.sv
// ID/EX, EX/MEM, MEM/WB control registers of the 5-stage MIPS core with
// load-use stall, branch/jump squash and EX-stage operand forwarding.

// One forwarding select per ALU operand: EX/MEM beats MEM/WB, $0 never forwards.
module fwd_unit #(
  parameter int W = 5
) (
  input  logic [W-1:0] src,
  input  logic         mem_reg_write,
  input  logic [W-1:0] mem_write_reg,
  input  logic         wb_reg_write,
  input  logic [W-1:0] wb_write_reg,
  output logic [1:0]   sel
);
  always_comb begin
    sel = 2'b00;
    if (mem_reg_write && (mem_write_reg != '0) && (mem_write_reg == src))
      sel = 2'b10;
    else if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == src))
      sel = 2'b01;
  end
endmodule

module control_hazard_pipeline #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  control_hazard_pipeline_if.slave   id_bus,
  input  logic                       ex_branch_taken,
  output logic                       stall_f,
  output logic                       flush_d,
  output logic                       ex_mem_to_reg,
  output logic                       ex_mem_write,
  output logic                       ex_branch,
  output logic                       ex_alu_src,
  output logic                       ex_reg_write,
  output logic [ALU_OP_WIDTH-1:0]    ex_alu_op,
  output logic [REG_ADDR_WIDTH-1:0]  ex_rs,
  output logic [REG_ADDR_WIDTH-1:0]  ex_rt,
  output logic [REG_ADDR_WIDTH-1:0]  ex_write_reg,
  output logic                       mem_mem_write,
  output logic                       mem_mem_to_reg,
  output logic                       mem_reg_write,
  output logic [REG_ADDR_WIDTH-1:0]  mem_write_reg,
  output logic                       wb_mem_to_reg,
  output logic                       wb_reg_write,
  output logic [REG_ADDR_WIDTH-1:0]  wb_write_reg,
  output logic [1:0]                 forward_a,
  output logic [1:0]                 forward_b
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic                      mem_to_reg;
    logic                      mem_write;
    logic                      branch;
    logic                      alu_src;
    logic                      reg_write;
    logic [ALU_OP_WIDTH-1:0]   alu_op;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] write_reg;
  } idex_t;

  typedef struct packed {
    logic                      mem_write;
    logic                      mem_to_reg;
    logic                      reg_write;
    logic [REG_ADDR_WIDTH-1:0] write_reg;
  } exmem_t;

  typedef struct packed {
    logic                      mem_to_reg;
    logic                      reg_write;
    logic [REG_ADDR_WIDTH-1:0] write_reg;
  } memwb_t;

  idex_t  idex_q, idex_d, id_pkt;
  exmem_t exmem_q;
  memwb_t memwb_q;

  logic use_rs, use_rt, ex_load, lu;

  always_comb begin
    id_pkt            = '0;
    id_pkt.mem_to_reg = id_bus.id_mem_to_reg;
    id_pkt.mem_write  = id_bus.id_mem_write;
    id_pkt.branch     = id_bus.id_branch;
    id_pkt.alu_src    = id_bus.id_alu_src;
    id_pkt.reg_write  = id_bus.id_reg_write;
    id_pkt.alu_op     = id_bus.id_alu_op;
    id_pkt.rs         = id_bus.id_rs;
    id_pkt.rt         = id_bus.id_rt;
    id_pkt.write_reg  = id_bus.id_reg_dst ? id_bus.id_rd : id_bus.id_rt;
  end

  // rt is a real source for R-type, beq and sw; immediate ALU ops and loads ignore it.
  assign use_rs  = !id_bus.id_jump;
  assign use_rt  = !id_bus.id_jump && (!id_bus.id_alu_src || id_bus.id_mem_write);
  // Stores also raise MemtoReg, so RegWrite is what marks a real load.
  assign ex_load = idex_q.mem_to_reg && idex_q.reg_write;
  assign lu      = ex_load && (idex_q.write_reg != '0) &&
                   ((use_rs && (id_bus.id_rs == idex_q.write_reg)) ||
                    (use_rt && (id_bus.id_rt == idex_q.write_reg)));

  always_comb begin
    stall_f = 1'b0;
    flush_d = 1'b0;
    idex_d  = id_pkt;
    if (rst) begin
      idex_d = '0;
    end else if (ex_branch_taken) begin
      flush_d = 1'b1;
      idex_d  = '0;
    end else if (lu) begin
      stall_f = 1'b1;
      idex_d  = '0;
    end else if (id_bus.id_jump) begin
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= '{mem_write:  idex_q.mem_write,  mem_to_reg: idex_q.mem_to_reg,
                   reg_write:  idex_q.reg_write,  write_reg:  idex_q.write_reg};
      memwb_q <= '{mem_to_reg: exmem_q.mem_to_reg, reg_write: exmem_q.reg_write,
                   write_reg:  exmem_q.write_reg};
    end
  end

  assign ex_mem_to_reg  = idex_q.mem_to_reg;
  assign ex_mem_write   = idex_q.mem_write;
  assign ex_branch      = idex_q.branch;
  assign ex_alu_src     = idex_q.alu_src;
  assign ex_reg_write   = idex_q.reg_write;
  assign ex_alu_op      = idex_q.alu_op;
  assign ex_rs          = idex_q.rs;
  assign ex_rt          = idex_q.rt;
  assign ex_write_reg   = idex_q.write_reg;
  assign mem_mem_write  = exmem_q.mem_write;
  assign mem_mem_to_reg = exmem_q.mem_to_reg;
  assign mem_reg_write  = exmem_q.reg_write;
  assign mem_write_reg  = exmem_q.write_reg;
  assign wb_mem_to_reg  = memwb_q.mem_to_reg;
  assign wb_reg_write   = memwb_q.reg_write;
  assign wb_write_reg   = memwb_q.write_reg;

  logic [NUM_OPS-1:0][REG_ADDR_WIDTH-1:0] ex_src;
  logic [NUM_OPS-1:0][1:0]                fwd;

  assign ex_src = {idex_q.rt, idex_q.rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    fwd_unit #(.W(REG_ADDR_WIDTH)) u_fwd (
      .src           (ex_src[g]),
      .mem_reg_write (exmem_q.reg_write),
      .mem_write_reg (exmem_q.write_reg),
      .wb_reg_write  (memwb_q.reg_write),
      .wb_write_reg  (memwb_q.write_reg),
      .sel           (fwd[g])
    );
  end

  assign forward_a = fwd[0];
  assign forward_b = fwd[1];
endmodule
